// File: rtl/weight_addr_gen_pkg.sv
// rtl/weight_addr_gen_pkg.sv - shared state encoding and default layer geometry
// Also imported by the layer controller so both sides agree on the encoding.
package weight_addr_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int N_IN_DEF  = 16;
  localparam int N_OUT_DEF = 8;
  localparam int AW_DEF    = 16;
  localparam int IDX_W     = 16;

endpackage

// File: rtl/weight_addr_gen_idx.sv
// rtl/weight_addr_gen_idx.sv - wrap counter: counts 0..max, returns to 0 on inc at max
// at_max is combinational so the next loop level can use it as its carry-in.
module idx_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic [W-1:0] max,
  output logic [W-1:0] count,
  output logic         at_max
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign at_max = (count_q == max);
  assign count  = count_q;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = at_max ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/weight_addr_gen.sv
// rtl/weight_addr_gen.sv - read address sequencer over (output neuron x input neuron)
// Emits BASE + out_idx*N_IN + in_idx, one address per accepted handshake.
module weight_addr_gen
  import weight_addr_gen_pkg::*;
#(
  parameter int          N_IN  = N_IN_DEF,
  parameter int          N_OUT = N_OUT_DEF,
  parameter int          AW    = AW_DEF,
  parameter int unsigned BASE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             addr_ready,
  output logic             addr_valid,
  output logic [AW-1:0]    addr,
  output logic [IDX_W-1:0] in_idx,
  output logic [IDX_W-1:0] out_idx,
  output logic             last_in,
  output logic             last_all,
  output logic             busy,
  output logic             done
);

  localparam logic [AW-1:0] BASE_A = AW'(BASE);
  localparam longint unsigned LAST_ADDR =
    longint'(BASE) + longint'(N_IN) * longint'(N_OUT) - 64'd1;

  if (N_IN < 1 || N_OUT < 1 || (LAST_ADDR >> AW) != 0) begin : g_bad_geometry
    $error("weight_addr_gen: layer does not fit in the address width");
  end

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;
  logic          xfer;
  logic          in_at_max;
  logic          out_at_max;

  assign xfer     = addr_valid & addr_ready;
  assign last_in  = in_at_max;
  assign last_all = in_at_max & out_at_max;
  assign addr     = addr_q;

  // Inner wrap carries into the outer counter, so indices return to 0 after last_all.
  idx_counter #(.W(IDX_W)) u_in_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (xfer),
    .max    (IDX_W'(N_IN - 1)),
    .count  (in_idx),
    .at_max (in_at_max)
  );

  idx_counter #(.W(IDX_W)) u_out_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (xfer & in_at_max),
    .max    (IDX_W'(N_OUT - 1)),
    .count  (out_idx),
    .at_max (out_at_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE_A;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (xfer) begin
          addr_d = last_all ? BASE_A : addr_q + AW'(1);
          if (last_all) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        addr_d  = BASE_A;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_RUN: begin
        addr_valid = 1'b1;
        busy       = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_weight_addr_gen.sv
// tb/tb_weight_addr_gen.sv - scoreboard bench: three geometries (4x2@0x100, 1x1@0, 16x8@0)
module tb_weight_addr_gen;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] in_idx;
    logic [15:0] out_idx;
    logic        li;
    logic        la;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start [3];
  logic        rdy   [3];
  logic        va    [3];
  logic [15:0] addr  [3];
  logic [15:0] in_i  [3];
  logic [15:0] out_i [3];
  logic        li    [3];
  logic        la    [3];
  logic        busy  [3];
  logic        done  [3];

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc   = 0;
  string nm [3] = '{"a", "b", "c"};

  exp_t        q [3][$];
  int          done_cnt [3];
  int          busy_cyc [3];
  int          xfer_cnt [3];
  int          la_cyc   [3];
  bit          held     [3];
  logic [49:0] prev     [3];
  logic [15:0] last_addr [3];

  exp_t tab_a [8];

  weight_addr_gen #(.N_IN(4), .N_OUT(2), .AW(16), .BASE(32'h100)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .addr_ready(rdy[0]),
    .addr_valid(va[0]), .addr(addr[0]), .in_idx(in_i[0]), .out_idx(out_i[0]),
    .last_in(li[0]), .last_all(la[0]), .busy(busy[0]), .done(done[0]));

  weight_addr_gen #(.N_IN(1), .N_OUT(1), .AW(16), .BASE(32'h0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .addr_ready(rdy[1]),
    .addr_valid(va[1]), .addr(addr[1]), .in_idx(in_i[1]), .out_idx(out_i[1]),
    .last_in(li[1]), .last_all(la[1]), .busy(busy[1]), .done(done[1]));

  weight_addr_gen dut_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .addr_ready(rdy[2]),
    .addr_valid(va[2]), .addr(addr[2]), .in_idx(in_i[2]), .out_idx(out_i[2]),
    .last_in(li[2]), .last_all(la[2]), .busy(busy[2]), .done(done[2]));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted address, checks stall stability and done timing.
  always @(negedge clk) begin
    for (int w = 0; w < 3; w++) begin
      logic [49:0] cur;
      exp_t        e;
      cur = {addr[w], in_i[w], out_i[w], li[w], la[w]};
      if (held[w] && va[w]) chk({nm[w], "_stall_hold"}, {14'd0, cur}, {14'd0, prev[w]});
      held[w] = va[w] && !rdy[w];
      prev[w] = cur;
      if (va[w] && rdy[w]) begin
        xfer_cnt[w]++;
        last_addr[w] = addr[w];
        if (la[w]) la_cyc[w] = cyc;
        if (q[w].size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL %s_extra_xfer: got addr %0h expected no transfer", nm[w], addr[w]);
        end else begin
          e = q[w].pop_front();
          chk({nm[w], "_xfer"}, {14'd0, cur}, {14'd0, e});
        end
      end
      if (done[w]) begin
        done_cnt[w]++;
        chk({nm[w], "_done_latency"}, 64'(cyc - la_cyc[w]), 64'd1);
      end
      if (busy[w]) busy_cyc[w]++;
    end
  end

  task automatic pulse_start(input int w);
    start[w] = 1'b1;
    @(posedge clk);
    #1;
    start[w] = 1'b0;
  endtask

  task automatic wait_done(input int w, input int budget);
    int d0;
    d0 = done_cnt[w];
    for (int k = 0; k < budget; k++) begin
      if (done_cnt[w] != d0) return;
      @(posedge clk);
      #1;
    end
    n_vec++;
    n_err++;
    $display("FAIL %s_done_timeout: got no done within %0d cycles, expected one", nm[w], budget);
  endtask

  task automatic push_a(input int n);
    for (int k = 0; k < n; k++) q[0].push_back(tab_a[k]);
  endtask

  initial begin
    int  d0;
    int  b0;
    int  x0;
    bit  seen;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_t e;

    tab_a = '{
      '{16'h100, 16'd0, 16'd0, 1'b0, 1'b0},
      '{16'h101, 16'd1, 16'd0, 1'b0, 1'b0},
      '{16'h102, 16'd2, 16'd0, 1'b0, 1'b0},
      '{16'h103, 16'd3, 16'd0, 1'b1, 1'b0},
      '{16'h104, 16'd0, 16'd1, 1'b0, 1'b0},
      '{16'h105, 16'd1, 16'd1, 1'b0, 1'b0},
      '{16'h106, 16'd2, 16'd1, 1'b0, 1'b0},
      '{16'h107, 16'd3, 16'd1, 1'b1, 1'b1}
    };
    rst_n = 1'b0;
    for (int w = 0; w < 3; w++) begin
      start[w] = 1'b0;
      rdy[w]   = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr",  64'(addr[0]), 64'h100);
    chk("rst_in",    64'(in_i[0]), 64'd0);
    chk("rst_out",   64'(out_i[0]), 64'd0);
    chk("rst_valid", 64'(va[0]), 64'd0);
    chk("rst_busy",  64'(busy[0]), 64'd0);
    chk("rst_done",  64'(done[0]), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-rate layer.
    rdy[0] = 1'b1;
    push_a(8);
    b0 = busy_cyc[0];
    d0 = done_cnt[0];
    pulse_start(0);
    chk("a_first_valid", 64'(va[0]), 64'd1);
    chk("a_first_addr", 64'(addr[0]), 64'h100);
    wait_done(0, 40);
    chk("a_busy_cycles", 64'(busy_cyc[0] - b0), 64'd8);
    chk("a_done_count", 64'(done_cnt[0] - d0), 64'd1);
    chk("a_queue_empty", 64'(q[0].size()), 64'd0);

    // Stalled layer, ready pattern 1,0,0,1.
    push_a(8);
    d0 = done_cnt[0];
    pulse_start(0);
    for (int k = 0; k < 80 && done_cnt[0] == d0; k++) begin
      rdy[0] = pat[k % 4];
      @(posedge clk);
      #1;
    end
    chk("a_stall_done_count", 64'(done_cnt[0] - d0), 64'd1);
    chk("a_stall_queue_empty", 64'(q[0].size()), 64'd0);

    // Start mid-run and on the DONE cycle must be ignored.
    rdy[0] = 1'b1;
    push_a(8);
    d0 = done_cnt[0];
    pulse_start(0);
    repeat (2) @(posedge clk);
    #1;
    pulse_start(0);
    chk("a_midrun_start_ignored", 64'(addr[0]), 64'h103);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = done[0];
    end
    chk("a_done_seen", 64'(seen), 64'd1);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    chk("a_done_cycle_start_ignored", 64'(va[0]), 64'd0);
    chk("a_done_once", 64'(done_cnt[0] - d0), 64'd1);
    push_a(8);
    pulse_start(0);
    chk("a_restart_valid", 64'(va[0]), 64'd1);
    chk("a_restart_addr", 64'(addr[0]), 64'h100);
    wait_done(0, 40);
    chk("a_restart_queue_empty", 64'(q[0].size()), 64'd0);

    // Reset after three transfers.
    push_a(3);
    d0 = done_cnt[0];
    pulse_start(0);
    repeat (3) @(posedge clk);
    #1;
    chk("a_pre_reset_addr", 64'(addr[0]), 64'h103);
    rst_n = 1'b0;
    #1;
    chk("a_mid_rst_addr",  64'(addr[0]), 64'h100);
    chk("a_mid_rst_in",    64'(in_i[0]), 64'd0);
    chk("a_mid_rst_out",   64'(out_i[0]), 64'd0);
    chk("a_mid_rst_valid", 64'(va[0]), 64'd0);
    chk("a_mid_rst_busy",  64'(busy[0]), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("a_mid_rst_no_done", 64'(done_cnt[0] - d0), 64'd0);
    chk("a_mid_rst_queue_empty", 64'(q[0].size()), 64'd0);
    push_a(8);
    pulse_start(0);
    wait_done(0, 40);
    chk("a_post_rst_done", 64'(done_cnt[0] - d0), 64'd1);
    chk("a_post_rst_queue_empty", 64'(q[0].size()), 64'd0);

    // Degenerate 1x1 layer.
    rdy[1] = 1'b1;
    q[1].push_back('{16'h0, 16'd0, 16'd0, 1'b1, 1'b1});
    pulse_start(1);
    chk("b_last_in_run", 64'(li[1]), 64'd1);
    wait_done(1, 20);
    chk("b_busy_cycles", 64'(busy_cyc[1]), 64'd1);
    chk("b_done_count", 64'(done_cnt[1]), 64'd1);
    chk("b_queue_empty", 64'(q[1].size()), 64'd0);

    // Default 16x8 layer with random back-pressure.
    for (int o = 0; o < 8; o++) begin
      for (int i = 0; i < 16; i++) begin
        e.addr    = 16'(o * 16 + i);
        e.in_idx  = 16'(i);
        e.out_idx = 16'(o);
        e.li      = (i == 15);
        e.la      = (i == 15) && (o == 7);
        q[2].push_back(e);
      end
    end
    d0 = done_cnt[2];
    x0 = xfer_cnt[2];
    rdy[2] = 1'b1;
    pulse_start(2);
    for (int k = 0; k < 3000 && done_cnt[2] == d0; k++) begin
      rdy[2] = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    chk("c_done_count", 64'(done_cnt[2] - d0), 64'd1);
    chk("c_xfer_count", 64'(xfer_cnt[2] - x0), 64'd128);
    chk("c_final_addr", 64'(last_addr[2]), 64'd127);
    chk("c_queue_empty", 64'(q[2].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
